// File: rtl/order_dispatch_queue.sv
// Sequence-tagging FIFO between risk management and the exchange interface.
// Define ORDER_DISPATCH_THROTTLE_EN to compile in the token-bucket rate limiter.
module order_dispatch_queue #(
  parameter int DEPTH         = 16,
  parameter int SEQ_W         = 16,
  parameter int TOKEN_MAX     = 8,
  parameter int REFILL_PERIOD = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              trade_data,
  input  logic                     trade_valid,
  input  logic                     trade_approved,
  output logic                     ord_valid,
  input  logic                     ord_ready,
  output logic [31:0]              ord_data,
  output logic [SEQ_W-1:0]         ord_seq,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              drop_count,
  output logic [15:0]              reject_count,
  output logic                     throttle_active
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REFILL_PERIOD < 1 || TOKEN_MAX < 1)
  begin : g_param_check
    $error("order_dispatch_queue: illegal parameter combination");
  end

  typedef enum logic {S_EMPTY, S_PRESENT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        data_mem [DEPTH];
  logic [SEQ_W-1:0]   seq_mem  [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   buf_cnt_q, buf_cnt_d;
  logic [SEQ_W-1:0]   seq_q;
  logic [31:0]        ord_data_q;
  logic [SEQ_W-1:0]   ord_seq_q;
  logic [15:0]        drop_q, reject_q;

  logic               pop, push_req, push_acc, load, can_release;
  logic [CNT_W-1:0]   fill;

  assign ord_valid = (state_q == S_PRESENT);
  assign pop       = ord_valid && ord_ready;
  assign fill      = buf_cnt_q + CNT_W'(ord_valid);
  assign push_req  = trade_valid && trade_approved;
  // A pop on the same edge frees the presented slot, so a full queue still accepts.
  assign push_acc  = push_req && ((fill < CNT_W'(DEPTH)) || pop);
  assign load      = (buf_cnt_q != '0) && can_release && (!ord_valid || pop);

`ifdef ORDER_DISPATCH_THROTTLE_EN
  localparam int TOK_W = $clog2(TOKEN_MAX + 1);
  localparam int TIM_W = $clog2(REFILL_PERIOD + 1);

  logic [TOK_W-1:0] tokens_q, tokens_d;
  logic [TIM_W-1:0] timer_q, timer_d;
  logic             refill;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    refill   = (timer_q == TIM_W'(REFILL_PERIOD - 1));
    timer_d  = refill ? '0 : timer_q + TIM_W'(1);
    tokens_d = tokens_q;
    if (refill && !pop && tokens_q != TOK_W'(TOKEN_MAX)) tokens_d = tokens_q + TOK_W'(1);
    else if (pop && !refill)                             tokens_d = tokens_q - TOK_W'(1);
  end

  // Release is judged on the post-update token count; a presented order always holds a token.
  assign can_release     = (tokens_d != '0);
  assign throttle_active = (tokens_q == '0) && (fill != '0) && !ord_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      tokens_q <= TOK_W'(TOKEN_MAX);
      timer_q  <= '0;
    end else begin
      tokens_q <= tokens_d;
      timer_q  <= timer_d;
    end
  end
`else
  assign can_release     = 1'b1;
  assign throttle_active = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    buf_cnt_d = buf_cnt_q + CNT_W'(push_acc) - CNT_W'(load);
    if (load)     state_d = S_PRESENT;
    else if (pop) state_d = S_EMPTY;
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push_acc && !rst) begin
      data_mem[wr_ptr_q] <= trade_data;
      seq_mem[wr_ptr_q]  <= seq_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      buf_cnt_q  <= '0;
      seq_q      <= '0;
      ord_data_q <= '0;
      ord_seq_q  <= '0;
      drop_q     <= '0;
      reject_q   <= '0;
    end else begin
      state_q   <= state_d;
      buf_cnt_q <= buf_cnt_d;
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        seq_q    <= seq_q + SEQ_W'(1);
      end
      if (load) begin
        ord_data_q <= data_mem[rd_ptr_q];
        ord_seq_q  <= seq_mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + AW'(1);
      end
      if (push_req && !push_acc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (trade_valid && !trade_approved && reject_q != 16'hFFFF) reject_q <= reject_q + 16'd1;
    end
  end

  assign ord_data     = ord_data_q;
  assign ord_seq      = ord_seq_q;
  assign fill_level   = fill;
  assign drop_count   = drop_q;
  assign reject_count = reject_q;

endmodule

// File: doc/order_dispatch_queue.md
# order_dispatch_queue

Downstream neighbour of the risk-management stage: captures every trade that risk approves, tags it with a sequence number, buffers it, and presents it to the order-execution/exchange interface over a valid/ready handshake. Risk management has no backpressure, so overflow is dropped and counted rather than stalled. An optional token-bucket throttle caps the outbound order rate.

## Interface
- DEPTH, 16: total order capacity, including the presented order; power of two, at least 2.
- SEQ_W, 16: sequence-tag width.
- TOKEN_MAX, 8: token-bucket capacity; only used with the throttle.
- REFILL_PERIOD, 100: cycles per token refill, at least 1; only used with the throttle.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- trade_data  in  32  trade amount from risk management.
- trade_valid  in  1  trade presented this cycle.
- trade_approved  in  1  risk verdict, qualified by trade_valid in the same cycle.
- ord_valid  out  1  order presented downstream.
- ord_ready  in  1  downstream accepts the order.
- ord_data  out  32  order amount.
- ord_seq  out  SEQ_W  order sequence tag.
- fill_level  out  $clog2(DEPTH)+1  orders held, including the presented one.
- drop_count  out  16  approved trades lost to a full queue; saturates at 16'hFFFF.
- reject_count  out  16  trades with trade_valid=1 and trade_approved=0; saturates.
- throttle_active  out  1  orders are held because the bucket has no tokens.

## Operation
- Push: at a rising edge with trade_valid=1 and trade_approved=1.
  - Accepted when fill_level<DEPTH, or when a pop occurs at that same edge.
  - Otherwise the trade is dropped and drop_count increments.
- Reject: at an edge with trade_valid=1 and trade_approved=0, reject_count increments. trade_data is ignored.
- Sequence tag:
  - Assigned at push from an internal counter.
  - The counter is 0 after reset and increments only on accepted pushes.
  - It wraps from 2^SEQ_W-1 to 0.
  - Dropped and rejected trades do not consume a tag.
- Structure: a circular buffer feeds a registered output stage. Order is strictly FIFO.
- Output state machine:
  - EMPTY: ord_valid=0. Moves to PRESENT one edge after an order becomes available and can be released.
  - PRESENT: ord_valid=1, with ord_data and ord_seq held stable.
  - Pop: an edge with ord_valid && ord_ready.
  - On pop, the stage loads the next order on the same edge and stays in PRESENT (back-to-back, one order per cycle). If no order is available, it returns to EMPTY.
- fill_level: changes by +1 on push, -1 on pop, and 0 on simultaneous push and pop.
- Counters: saturate and never wrap.

## Timing
- Reset values: ord_valid=0, ord_data=0, ord_seq=0, fill_level=0, drop_count=0, reject_count=0, throttle_active=0.
  - Tokens reset to TOKEN_MAX; the refill timer resets to 0.
- Reset asserted mid-operation:
  - Flushes all orders; the outputs above are cleared at that edge.
  - A trade arriving while rst=1 is ignored.
- Latency from an empty queue: push at edge N gives ord_valid=1 after edge N+1. Minimum latency is 2 edges.
- Handshake rules:
  - Once ord_valid rises, it and the payload stay constant until the pop edge.
  - ord_ready may be high while ord_valid=0; this has no effect.
- Full with simultaneous pop: the push is accepted and fill_level stays at DEPTH.

## Configuration
- ORDER_DISPATCH_THROTTLE_EN defined: the token bucket is compiled in.
  - Each pop consumes one token.
  - Every REFILL_PERIOD cycles, one token is added, saturating at TOKEN_MAX.
  - A refill and a pop on the same edge leave the token count unchanged.
  - The output stage only goes EMPTY→PRESENT, or loads the next order on a pop, when tokens remain after that edge's update.
  - throttle_active=1 when tokens=0 and fill_level>0 with ord_valid=0.
  - An already-presented order is never withdrawn.
- Not defined: no bucket logic, ord_valid is never gated, and throttle_active is tied to 0.

## Test plan
- Reset, then one approved trade 32'h00010000 with ord_ready=1.
  - ord_valid rises 2 edges after the push, with ord_data=32'h00010000 and ord_seq=0.
  - fill_level returns to 0 after the pop.
- Hold ord_ready=0 and push DEPTH+3 approved trades.
  - fill_level=16, drop_count=3, first ord_seq=0.
  - After ord_ready=1, tags 0..15 drain one per cycle, in order.
- Alternate approved and unapproved trades (8 total).
  - reject_count=4; the emitted ord_seq values are 0,1,2,3 with no gaps.
- Force the sequence counter near wrap (SEQ_W=4) and push 18 trades while draining.
  - ord_seq runs 0..15, 0, 1.
- Throttle build with TOKEN_MAX=2, REFILL_PERIOD=10: push 5 trades with ord_ready=1.
  - Two orders leave back-to-back, then throttle_active=1.
  - After that, one order leaves per 10 cycles.
- Assert rst for one cycle while 5 orders are queued and ord_valid=1.
  - All outputs are 0 on the next cycle.
  - A following push gets ord_seq=0.
